// File: rtl/countdown_timer_pkg.sv
// Shared constants for the MM:SS countdown timer: state encoding and default
// counter-chain moduli/width.
package countdown_timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DEF_MAX_SEC = 60;
    localparam int DEF_MAX_MIN = 60;
    localparam int DEF_W       = 6;

endpackage

// File: rtl/countdown_timer_down_counter.sv
// Loadable modulo-MAX down counter; wraps 0 -> MAX-1 when enabled and flags a
// zero count combinationally so the next stage can borrow.
module down_counter #(
    parameter int N   = 6,
    parameter int MAX = 60
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [N-1:0] i_load_val,
    output logic [N-1:0] o_count,
    output logic         o_borrow
);

    localparam logic [N-1:0] TOP = N'(MAX - 1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_count <= '0;
        end else if (i_load) begin
            o_count <= i_load_val;
        end else if (i_en) begin
            if (o_count == '0) begin
                o_count <= TOP;
            end else begin
                o_count <= o_count - 1'b1;
            end
        end
    end

    assign o_borrow = (o_count == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable MM:SS countdown timer: preset load with saturation, run/pause/done
// control and a one-cycle expiry pulse on reaching 00:00 from RUN.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int MAX_SEC = DEF_MAX_SEC,
    parameter int MAX_MIN = DEF_MAX_MIN,
    parameter int W       = DEF_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_tick,
    input  logic         i_load,
    input  logic [W-1:0] i_preset_min,
    input  logic [W-1:0] i_preset_sec,
    input  logic         i_start,
    input  logic         i_pause,
    output logic [W-1:0] o_min,
    output logic [W-1:0] o_sec,
    output logic         o_running,
    output logic         o_done,
    output logic         o_expire
);

    localparam logic [W-1:0] SEC_TOP = W'(MAX_SEC - 1);
    localparam logic [W-1:0] MIN_TOP = W'(MAX_MIN - 1);
    localparam logic [W-1:0] ONE     = W'(1);

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic [W-1:0] load_min;
    logic [W-1:0] load_sec;
    logic         sec_borrow;
    logic         min_borrow;
    logic         tick_run;
    logic         load_ok;
    logic         at_zero;
    logic         hit_zero;

    assign load_sec = (i_preset_sec > SEC_TOP) ? SEC_TOP : i_preset_sec;
    assign load_min = (i_preset_min > MIN_TOP) ? MIN_TOP : i_preset_min;

    assign tick_run = (state == ST_RUN) && i_tick;
    assign load_ok  = i_load && (state != ST_RUN);
    assign at_zero  = sec_borrow && min_borrow;
    // RUN never holds 00:00, so the only tick that lands on zero is from 00:01.
    assign hit_zero = tick_run && min_borrow && (o_sec == ONE);

    down_counter #(
        .N   (W),
        .MAX (MAX_SEC)
    ) u_sec (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (tick_run),
        .i_load     (load_ok),
        .i_load_val (load_sec),
        .o_count    (o_sec),
        .o_borrow   (sec_borrow)
    );

    down_counter #(
        .N   (W),
        .MAX (MAX_MIN)
    ) u_min (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (tick_run && sec_borrow),
        .i_load     (load_ok),
        .i_load_val (load_min),
        .o_count    (o_min),
        .o_borrow   (min_borrow)
    );

    // A pause request outranks start, so pause+start in IDLE/PAUSE does nothing.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_PAUSE: begin
                if (i_load) begin
                    state_nxt = ST_IDLE;
                end else if (!i_pause && i_start && !at_zero) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (hit_zero) begin
                    state_nxt = ST_DONE;
                end else if (i_pause) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (i_load) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            o_expire <= 1'b0;
        end else begin
            state    <= state_nxt;
            o_expire <= hit_zero;
        end
    end

    assign o_running = (state == ST_RUN);
    assign o_done    = (state == ST_DONE);

endmodule
